// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-ported integer register file.
// Imported by the interface, the scoreboard and the top level.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_RD     = 2;
  localparam int ZERO_REG       = 0;
  localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

  function automatic int num_regs(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bundle of write, read, issue and scoreboard-status signals of regfile_mp.
// master = pipeline side, slave = register file side.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD
) ();

  logic                         wen;
  logic [ADDR_WIDTH-1:0]        waddr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic                         set_busy;
  logic [ADDR_WIDTH-1:0]        set_addr;
  logic [ADDR_WIDTH:0]          busy_cnt;
  logic                         any_busy;

  modport master (
    output wen, waddr, wdata, raddr, set_busy, set_addr,
    input  rdata, rbusy, busy_cnt, any_busy
  );

  modport slave (
    input  wen, waddr, wdata, raddr, set_busy, set_addr,
    output rdata, rbusy, busy_cnt, any_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register plus a running count,
// so decode can spot RAW hazards against in-flight writebacks.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_busy,
  input  logic [ADDR_WIDTH-1:0]        set_addr,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] qaddr,
  output logic [NUM_RD-1:0]            rbusy,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int                    DEPTH = num_regs(ADDR_WIDTH);
  localparam int                    CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO  = ADDR_WIDTH'(ZERO_REG);

  typedef logic [CW-1:0] cnt_t;

  logic [DEPTH-1:0] busy;
  logic             set_ok;
  logic             clr_ok;
  logic             cnt_inc;
  logic             cnt_dec;

  // A clear on the index being set this cycle is cancelled: the set wins.
  always_comb begin
    set_ok  = set_busy && (set_addr != ZERO);
    clr_ok  = wen && (waddr != ZERO);
    cnt_inc = set_ok && !busy[set_addr];
    cnt_dec = clr_ok && busy[waddr] && !(set_ok && (set_addr == waddr));
  end

  // NOTE: non-blocking assignments for all state; the second NBA to the same
  // bit takes effect, which is exactly the set-over-clear priority we want.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (clr_ok) busy[waddr]    <= 1'b0;
      if (set_ok) busy[set_addr] <= 1'b1;
      busy_cnt <= busy_cnt + cnt_t'(cnt_inc) - cnt_t'(cnt_dec);
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rbusy[i] = busy[qaddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      if ((BYPASS != 0) && clr_ok && (waddr == qaddr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          !(set_ok && (set_addr == waddr)))
        rbusy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file: NUM_RD combinational reads, one
// synchronous write, optional write-to-read bypass and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int BYPASS     = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int                    DEPTH = num_regs(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO  = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic [ADDR_WIDTH-1:0] ra;

  assign wr_ok = bus.wen && (bus.waddr != ZERO);

  // NOTE: the array is reset because all entries must read 0 after reset;
  // this forces flops rather than a RAM macro, acceptable at this depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata = '0;
    ra        = ZERO;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (ra != ZERO) begin
        if ((BYPASS != 0) && wr_ok && (bus.waddr == ra))
          bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
        else
          bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_busy (bus.set_busy),
    .set_addr (bus.set_addr),
    .wen      (bus.wen),
    .waddr    (bus.waddr),
    .qaddr    (bus.raddr),
    .rbusy    (bus.rbusy),
    .busy_cnt (bus.busy_cnt)
  );

  assign bus.any_busy = (bus.busy_cnt != '0);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector and randomised bench for regfile_mp, with a bypassing and a
// non-bypassing instance driven by identical stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR*AW-1:0] raddr;
  logic             set_busy;
  logic [AW-1:0]    set_addr;

  regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) if_b ();
  regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) if_n ();

  assign if_b.wen = wen;  assign if_b.waddr = waddr;  assign if_b.wdata = wdata;
  assign if_b.raddr = raddr;  assign if_b.set_busy = set_busy;  assign if_b.set_addr = set_addr;
  assign if_n.wen = wen;  assign if_n.waddr = waddr;  assign if_n.wdata = wdata;
  assign if_n.raddr = raddr;  assign if_n.set_busy = set_busy;  assign if_n.set_addr = set_addr;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b));
  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .bus(if_n));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic sb, input logic [AW-1:0] sa, input logic [NR*AW-1:0] ra);
    wen = we; waddr = wa; wdata = wd; set_busy = sb; set_addr = sa; raddr = ra;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic             set_busy;
    logic [AW-1:0]    set_addr;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rd_b;
    logic [NR*DW-1:0] rd_n;
    logic [NR-1:0]    rb_b;
    logic [NR-1:0]    rb_n;
    logic [AW:0]      cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(
    input int unsigned we, wa, wd, sb, sa, r0, r1, r2,
    input int unsigned bd0, bd1, bd2, nd0, nd1, nd2, rbb, rbn, cnt);
    vec_t v;
    v.wen = we[0];  v.waddr = wa[AW-1:0];  v.wdata = wd;
    v.set_busy = sb[0];  v.set_addr = sa[AW-1:0];
    v.raddr = {r2[AW-1:0], r1[AW-1:0], r0[AW-1:0]};
    v.rd_b  = {bd2, bd1, bd0};
    v.rd_n  = {nd2, nd1, nd0};
    v.rb_b  = rbb[NR-1:0];
    v.rb_n  = rbn[NR-1:0];
    v.cnt   = cnt[AW:0];
    return v;
  endfunction

  // ---------------- reference model for the random phase ----------------
  logic [DW-1:0]  m_mem [32];
  logic [31:0]    m_busy;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  task automatic model_clock();
    logic [31:0] nb;
    nb = m_busy;
    if (wen && waddr != 0) begin
      m_mem[waddr] = wdata;
      nb[waddr] = 1'b0;
    end
    if (set_busy && set_addr != 0) nb[set_addr] = 1'b1;
    m_busy = nb;
  endtask

  function automatic logic [NR*DW-1:0] exp_rd(input bit byp);
    logic [NR*DW-1:0] r;
    logic [AW-1:0] a;
    r = '0;
    for (int i = 0; i < NR; i++) begin
      a = raddr[i*AW +: AW];
      if (a == 0)                           r[i*DW +: DW] = '0;
      else if (byp && wen && waddr == a)    r[i*DW +: DW] = wdata;
      else                                  r[i*DW +: DW] = m_mem[a];
    end
    return r;
  endfunction

  function automatic logic [NR-1:0] exp_rb(input bit byp);
    logic [NR-1:0] r;
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) begin
      a = raddr[i*AW +: AW];
      r[i] = m_busy[a];
      if (byp && wen && a != 0 && waddr == a && !(set_busy && set_addr == a)) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(1, 0, 32'hDEADBEEF, 1, 0,  0, 0, 0,   0, 0, 0,  0, 0, 0,  'b000, 'b000, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 5, 31,  0, 0, 0,  0, 0, 0,  'b000, 'b000, 0);
    vecs[2]  = mk(1, 7, 32'h1234, 0, 0,  7, 7, 0,  32'h1234, 32'h1234, 0,  0, 0, 0,  'b000, 'b000, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,  7, 7, 0,  32'h1234, 32'h1234, 0,  32'h1234, 32'h1234, 0,  'b000, 'b000, 0);
    vecs[4]  = mk(0, 0, 0, 1, 3,  3, 7, 0,  0, 32'h1234, 0,  0, 32'h1234, 0,  'b000, 'b000, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,  3, 3, 7,  0, 0, 32'h1234,  0, 0, 32'h1234,  'b011, 'b011, 1);
    vecs[6]  = mk(1, 3, 32'hAAAA5555, 1, 3,  3, 0, 7,  32'hAAAA5555, 0, 32'h1234,  0, 0, 32'h1234,  'b001, 'b001, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0,  3, 0, 7,  32'hAAAA5555, 0, 32'h1234,  32'hAAAA5555, 0, 32'h1234,  'b001, 'b001, 1);
    vecs[8]  = mk(1, 3, 32'h11112222, 0, 0,  3, 3, 7,  32'h11112222, 32'h11112222, 32'h1234,
                  32'hAAAA5555, 32'hAAAA5555, 32'h1234,  'b000, 'b011, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0,  3, 3, 7,  32'h11112222, 32'h11112222, 32'h1234,
                  32'h11112222, 32'h11112222, 32'h1234,  'b000, 'b000, 0);
    vecs[10] = mk(1, 7, 32'h77, 1, 9,  9, 7, 0,  0, 32'h77, 0,  0, 32'h1234, 0,  'b000, 'b000, 0);
    vecs[11] = mk(0, 0, 0, 1, 10,  9, 7, 10,  0, 32'h77, 0,  0, 32'h77, 0,  'b001, 'b001, 1);
    vecs[12] = mk(1, 10, 32'hA0, 1, 9,  9, 10, 10,  0, 32'hA0, 32'hA0,  0, 0, 0,  'b001, 'b111, 2);
    vecs[13] = mk(0, 0, 0, 0, 0,  9, 10, 0,  0, 32'hA0, 0,  0, 32'hA0, 0,  'b001, 'b001, 1);
    vecs[14] = mk(1, 9, 32'h99, 0, 0,  9, 9, 9,  32'h99, 32'h99, 32'h99,  0, 0, 0,  'b000, 'b111, 1);
    vecs[15] = mk(0, 0, 0, 0, 0,  9, 3, 31,  32'h99, 32'h11112222, 0,  32'h99, 32'h11112222, 0,  'b000, 'b000, 0);

    // reset state
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, {5'd0, 5'd31, 5'd5});
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset rd_b", if_b.rdata, '0);
    check("reset rd_n", if_n.rdata, '0);
    check("reset rbusy", {if_b.rbusy, if_n.rbusy}, '0);
    check("reset cnt", {if_b.busy_cnt, if_b.any_busy}, '0);
    @(negedge clk); rst = 1'b0;

    // directed table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].set_busy, vecs[i].set_addr, vecs[i].raddr);
      #1;
      check($sformatf("row%0d rd_b", i), if_b.rdata, vecs[i].rd_b);
      check($sformatf("row%0d rd_n", i), if_n.rdata, vecs[i].rd_n);
      check($sformatf("row%0d rbusy_b", i), if_b.rbusy, vecs[i].rb_b);
      check($sformatf("row%0d rbusy_n", i), if_n.rbusy, vecs[i].rb_n);
      check($sformatf("row%0d cnt_b", i), if_b.busy_cnt, vecs[i].cnt);
      check($sformatf("row%0d cnt_n", i), if_n.busy_cnt, vecs[i].cnt);
      check($sformatf("row%0d any_b", i), if_b.any_busy, (vecs[i].cnt != 0));
      check($sformatf("row%0d any_n", i), if_n.any_busy, (vecs[i].cnt != 0));
    end

    // asynchronous reset mid-run with a write held during reset
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 5'd4, {5'd0, 5'd0, 5'd4});
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h5555, 1'b0, '0, {5'd0, 5'd7, 5'd5});
    #1;
    check("midrst cnt_b", if_b.busy_cnt, '0);
    check("midrst any_b", if_b.any_busy, 1'b0);
    check("midrst rd_b", if_b.rdata, {32'h0, 32'h0, 32'h5555});
    check("midrst rd_n", if_n.rdata, '0);
    check("midrst rbusy", {if_b.rbusy, if_n.rbusy}, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, {5'd3, 5'd31, 5'd5});
    #1;
    check("postrst rd_b", if_b.rdata, '0);
    check("postrst rd_n", if_n.rdata, '0);
    check("postrst rbusy", {if_b.rbusy, if_n.rbusy}, '0);
    check("postrst cnt", {if_b.busy_cnt, if_n.busy_cnt}, '0);
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hC0DE, 1'b0, '0, {5'd3, 5'd31, 5'd5});
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, {5'd3, 5'd31, 5'd5});
    #1;
    check("first write rd_b", if_b.rdata, {32'h0, 32'h0, 32'hC0DE});
    check("first write rd_n", if_n.rdata, {32'h0, 32'h0, 32'hC0DE});

    // randomised phase against the reference model
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), 1'($urandom_range(0, 1)), rnd_addr(),
            {rnd_addr(), rnd_addr(), rnd_addr()});
      #1;
      check($sformatf("rnd%0d rd_b", c), if_b.rdata, exp_rd(1'b1));
      check($sformatf("rnd%0d rd_n", c), if_n.rdata, exp_rd(1'b0));
      check($sformatf("rnd%0d rbusy_b", c), if_b.rbusy, exp_rb(1'b1));
      check($sformatf("rnd%0d rbusy_n", c), if_n.rbusy, exp_rb(1'b0));
      check($sformatf("rnd%0d cnt_b", c), {if_b.busy_cnt, if_b.any_busy},
            {(AW+1)'($countones(m_busy)), m_busy != 0});
      check($sformatf("rnd%0d cnt_n", c), {if_n.busy_cnt, if_n.any_busy},
            {(AW+1)'($countones(m_busy)), m_busy != 0});
      @(posedge clk);
      model_clock();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
